// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and types for the LED pattern blocks
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROL   = 2'd0,
    MODE_ROR   = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int unsigned CNT_MAX_DEFAULT = 500_000;

endpackage

// File: rtl/led_tick_div.sv
// rtl/led_tick_div.sv - free-running prescaler producing a step tick every limit cycles
module led_tick_div (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] limit,
  output logic        tick
);

  logic [31:0] timer_q;
  logic        at_limit;

  // >= rather than == so a sudden drop in limit wraps on the next cycle instead of running to 2^32
  assign at_limit = (timer_q >= (limit - 32'd1));
  assign tick     = en && !clr && at_limit;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      timer_q <= '0;
    end else if (clr) begin
      timer_q <= '0;
    end else if (en) begin
      timer_q <= at_limit ? 32'd0 : (timer_q + 32'd1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator: rotate left/right, ping-pong and blink at a prescaled rate
module led_pattern_gen #(
  parameter int unsigned       LED_W   = 4,
  parameter int unsigned       CNT_MAX = led_pkg::CNT_MAX_DEFAULT,
  parameter int unsigned       SPD_W   = 2,
  parameter logic [LED_W-1:0]  INIT    = LED_W'(4'b0111)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              en,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [SPD_W-1:0]  speed,
  output logic [LED_W-1:0]  led,
  output logic              step
);
  import led_pkg::*;

  localparam int POS_W = $clog2(LED_W);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);

  logic [31:0]       limit;
  logic              tick;
  logic [LED_W-1:0]  led_q, led_d;
  logic [POS_W-1:0]  pos_q, pos_d, pos_inc, pos_dec;
  dir_t              dir_q, dir_d;
  logic              step_q;

  assign limit = 32'(CNT_MAX) >> speed;

  led_tick_div u_tick_div (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (en),
    .clr     (restart),
    .limit   (limit),
    .tick    (tick)
  );

  function automatic logic [LED_W-1:0] rol(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

  function automatic logic [LED_W-1:0] ror(input logic [LED_W-1:0] v);
    return {v[0], v[LED_W-1:1]};
  endfunction

  // pos wraps explicitly so non-power-of-two LED counts stay in range
  assign pos_inc = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
  assign pos_dec = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;

  always_comb begin
    led_d = led_q;
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick) begin
      case (mode_t'(mode))
        MODE_ROL: begin
          led_d = rol(led_q);
          pos_d = pos_inc;
        end
        MODE_ROR: begin
          led_d = ror(led_q);
          pos_d = pos_dec;
        end
        MODE_PING: begin
          if (dir_q == DIR_LEFT && pos_q == POS_MAX) begin
            dir_d = DIR_RIGHT;
            led_d = ror(led_q);
            pos_d = pos_dec;
          end else if (dir_q == DIR_RIGHT && pos_q == '0) begin
            dir_d = DIR_LEFT;
            led_d = rol(led_q);
            pos_d = pos_inc;
          end else if (dir_q == DIR_LEFT) begin
            led_d = rol(led_q);
            pos_d = pos_inc;
          end else begin
            led_d = ror(led_q);
            pos_d = pos_dec;
          end
        end
        MODE_BLINK: begin
          led_d = ~led_q;
        end
        default: begin
          led_d = led_q;
        end
      endcase
    end
  end

  // restart wins over a coincident tick; the prescaler sees it via clr
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      led_q  <= INIT;
      pos_q  <= '0;
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
    end else if (restart) begin
      led_q  <= INIT;
      pos_q  <= '0;
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= tick;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen
module tb_led_pattern_gen;

  logic       clk;
  logic       n_reset;
  logic       en;
  logic       restart;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [3:0] led;
  logic       step;

  int tests;
  int fails;
  int cyc;
  int r;

  typedef struct {
    int         at;
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];

  led_pattern_gen #(
    .LED_W   (4),
    .CNT_MAX (8),
    .SPD_W   (2),
    .INIT    (4'b0111)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (en),
    .restart (restart),
    .mode    (mode),
    .speed   (speed),
    .led     (led),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int off, input logic [3:0] v);
    exp_t e;
    e.at  = r + off;
    e.led = v;
    sb.push_back(e);
  endtask

  // monitor: every step pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (n_reset && !en) check("step_while_disabled", int'(step), 0);
    if (n_reset && step) begin
      if (sb.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("step_cycle", cyc, e.at);
        check("step_led", int'(led), int'(e.led));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    n_reset = 1'b0;
    en = 1'b0;
    restart = 1'b0;
    mode = 2'd0;
    speed = 2'd0;

    go_to(3);
    check("reset_led", int'(led), 4'b0111);
    check("reset_step", int'(step), 0);

    r = cyc;
    push(8, 4'b1110);   push(16, 4'b1101);  push(24, 4'b1011);  push(32, 4'b0111);
    push(40, 4'b1110);  push(48, 4'b1101);  push(56, 4'b1011);  push(64, 4'b1101);
    push(72, 4'b1110);  push(80, 4'b0111);  push(88, 4'b1110);
    push(95, 4'b1101);  push(97, 4'b1011);  push(99, 4'b1101);  push(101, 4'b1110);
    push(109, 4'b0001); push(117, 4'b1110);
    push(145, 4'b0001); push(153, 4'b1110); push(161, 4'b1101); push(169, 4'b1011);
    push(185, 4'b1000); push(193, 4'b0111);
    n_reset = 1'b1;
    en = 1'b1;

    go_to(r + 32);
    mode = 2'd2;
    go_to(r + 94);
    speed = 2'd2;
    go_to(r + 101);
    mode = 2'd3;
    speed = 2'd0;
    go_to(r + 120);
    en = 1'b0;
    go_to(r + 140);
    check("held_led", int'(led), 4'b1110);
    en = 1'b1;
    go_to(r + 153);
    mode = 2'd0;
    go_to(r + 169);
    check("pre_restart_led", int'(led), 4'b1011);
    go_to(r + 176);
    restart = 1'b1;
    go_to(r + 177);
    restart = 1'b0;
    check("restart_led", int'(led), 4'b0111);
    check("restart_step", int'(step), 0);
    mode = 2'd3;

    go_to(r + 201);
    check("pre_reset_led", int'(led), 4'b1000);
    check("pre_reset_step", int'(step), 1);
    #1;
    n_reset = 1'b0;
    #1;
    check("async_reset_led", int'(led), 4'b0111);
    check("async_reset_step", int'(step), 0);
    go_to(r + 205);
    check("reset_hold_led", int'(led), 4'b0111);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
